// File: rtl/b_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : b_resp_router
// Description : Routes AXI write responses (B channel) from one of five slave
//               ports to a single master port through a 2-entry FIFO. The
//               slave to serve is chosen by an external ordering controller
//               (B_slv_sel / hold). BREADY is combinational. The master side
//               is driven from registers.
// Options     : define B_RESP_ERR_CNT_EN to enable the saturating error
//               response counter on err_cnt. Without it, err_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module b_resp_router #(
  parameter int sID_width = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic [sID_width-1:0] s0_BID,
  input  logic [1:0]           s0_BRESP,
  input  logic                 s0_BVALID,
  output logic                 s0_BREADY,

  input  logic [sID_width-1:0] s1_BID,
  input  logic [1:0]           s1_BRESP,
  input  logic                 s1_BVALID,
  output logic                 s1_BREADY,

  input  logic [sID_width-1:0] s2_BID,
  input  logic [1:0]           s2_BRESP,
  input  logic                 s2_BVALID,
  output logic                 s2_BREADY,

  input  logic [sID_width-1:0] s3_BID,
  input  logic [1:0]           s3_BRESP,
  input  logic                 s3_BVALID,
  output logic                 s3_BREADY,

  input  logic [sID_width-1:0] s4_BID,
  input  logic [1:0]           s4_BRESP,
  input  logic                 s4_BVALID,
  output logic                 s4_BREADY,

  input  logic [2:0]           B_slv_sel,
  input  logic                 hold,

  output logic [sID_width-1:0] m_BID,
  output logic [1:0]           m_BRESP,
  output logic                 m_BVALID,
  input  logic                 m_BREADY,

  output logic [7:0]           err_cnt
);

  // Buffer depth is an architectural constant and cannot be overridden.
  localparam int depth   = 2;
  localparam int entry_w = sID_width + 2;

  // Selected-slave view of the B channel
  logic [sID_width-1:0] sel_bid;
  logic [1:0]           sel_bresp;
  logic                 sel_valid;

  // FIFO state
  logic [entry_w-1:0]   mem [depth];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  // Next-state terms
  logic                 full;
  logic                 accept;
  logic                 pop;
  logic                 rd_ptr_nxt;
  logic                 wr_ptr_nxt;
  logic [1:0]           count_nxt;
  logic [entry_w-1:0]   new_entry;
  logic [entry_w-1:0]   head_nxt;

  // Select the slave port named by the ordering controller; 5..7 select nothing.
  always_comb begin
    sel_bid   = '0;
    sel_bresp = 2'b00;
    sel_valid = 1'b0;
    case (B_slv_sel)
      3'd0: begin
        sel_bid   = s0_BID;
        sel_bresp = s0_BRESP;
        sel_valid = s0_BVALID;
      end
      3'd1: begin
        sel_bid   = s1_BID;
        sel_bresp = s1_BRESP;
        sel_valid = s1_BVALID;
      end
      3'd2: begin
        sel_bid   = s2_BID;
        sel_bresp = s2_BRESP;
        sel_valid = s2_BVALID;
      end
      3'd3: begin
        sel_bid   = s3_BID;
        sel_bresp = s3_BRESP;
        sel_valid = s3_BVALID;
      end
      3'd4: begin
        sel_bid   = s4_BID;
        sel_bresp = s4_BRESP;
        sel_valid = s4_BVALID;
      end
      default: begin
        sel_bid   = '0;
        sel_bresp = 2'b00;
        sel_valid = 1'b0;
      end
    endcase
  end

  // Full is taken from the registered count, so a same-cycle pop never frees
  // a slot for a same-cycle accept. reset_n gates acceptance so no BREADY is
  // seen while the block is held in reset.
  assign full      = (count == 2'd2);
  assign accept    = reset_n & ~hold & sel_valid & ~full;
  assign pop       = m_BVALID & m_BREADY;
  assign new_entry = {sel_bid, sel_bresp};

  // Combinational BREADY: only the selected port sees the accept.
  always_comb begin
    s0_BREADY = 1'b0;
    s1_BREADY = 1'b0;
    s2_BREADY = 1'b0;
    s3_BREADY = 1'b0;
    s4_BREADY = 1'b0;
    case (B_slv_sel)
      3'd0:    s0_BREADY = accept;
      3'd1:    s1_BREADY = accept;
      3'd2:    s2_BREADY = accept;
      3'd3:    s3_BREADY = accept;
      3'd4:    s4_BREADY = accept;
      default: ;
    endcase
  end

  // Pointer/count update and look-ahead of the next head entry, so that the
  // master outputs can be loaded straight into registers.
  always_comb begin
    rd_ptr_nxt = rd_ptr ^ pop;
    wr_ptr_nxt = wr_ptr ^ accept;
    count_nxt  = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
    // A beat written into the slot that becomes the head is the new head;
    // otherwise the head comes from storage. A write while holding never
    // lands on the head slot, which keeps the outputs stable under stall.
    if (accept && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = new_entry;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // FIFO storage, pointers and registered master-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      m_BVALID <= 1'b0;
      m_BID    <= '0;
      m_BRESP  <= 2'b00;
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (accept && (int'(wr_ptr) == i)) begin
          mem[i] <= new_entry;
        end
      end
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      m_BVALID <= (count_nxt != 2'd0);
      m_BID    <= head_nxt[entry_w-1:2];
      m_BRESP  <= head_nxt[1:0];
    end
  end

`ifdef B_RESP_ERR_CNT_EN
  logic [7:0] err_q;

  // Count SLVERR/DECERR responses as they leave towards the master; saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 8'd0;
    end else if (pop && m_BRESP[1] && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_b_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_b_resp_router
// Description : Self-checking bench for b_resp_router. A queue models the
//               2-entry FIFO: accepted beats are pushed when driven and popped
//               and compared as the master side delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b_resp_router;

  localparam int SW = 6;
`ifdef B_RESP_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [SW-1:0] s_bid   [5];
  logic [1:0]    s_bresp [5];
  logic [4:0]    s_bvalid;
  logic [4:0]    s_bready;
  logic [2:0]    sel;
  logic          hold;
  logic [SW-1:0] m_bid;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;
  logic [7:0]    err_cnt;

  logic [SW+1:0] exp_q [$];
  int            err_model;
  int            checks;
  int            failures;

  always #5 clk = ~clk;

  b_resp_router #(.sID_width(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s0_BID    (s_bid[0]), .s0_BRESP(s_bresp[0]), .s0_BVALID(s_bvalid[0]), .s0_BREADY(s_bready[0]),
    .s1_BID    (s_bid[1]), .s1_BRESP(s_bresp[1]), .s1_BVALID(s_bvalid[1]), .s1_BREADY(s_bready[1]),
    .s2_BID    (s_bid[2]), .s2_BRESP(s_bresp[2]), .s2_BVALID(s_bvalid[2]), .s2_BREADY(s_bready[2]),
    .s3_BID    (s_bid[3]), .s3_BRESP(s_bresp[3]), .s3_BVALID(s_bvalid[3]), .s3_BREADY(s_bready[3]),
    .s4_BID    (s_bid[4]), .s4_BRESP(s_bresp[4]), .s4_BVALID(s_bvalid[4]), .s4_BREADY(s_bready[4]),
    .B_slv_sel (sel),
    .hold      (hold),
    .m_BID     (m_bid),
    .m_BRESP   (m_bresp),
    .m_BVALID  (m_bvalid),
    .m_BREADY  (m_bready),
    .err_cnt   (err_cnt)
  );

  // Model of the accept condition, using the model's occupancy.
  function automatic bit exp_accept();
    if (sel > 3'd4) return 1'b0;
    return reset_n && !hold && s_bvalid[sel] && (exp_q.size() < 2);
  endfunction

  function automatic logic [4:0] exp_ready();
    if (exp_accept()) return 5'd1 << sel;
    return 5'd0;
  endfunction

  // One clock: decide push/pop from the inputs present before the edge,
  // update the model at the edge, return just after the next falling edge.
  task automatic tick();
    logic [SW+1:0] popped;
    bit            acc;
    bit            pop;
    acc = exp_accept();
    pop = (exp_q.size() > 0) && m_bready && reset_n;
    @(posedge clk);
    if (pop) begin
      popped = exp_q.pop_front();
      if (popped[1] && err_model < 255) err_model++;
    end
    if (acc) exp_q.push_back({s_bid[sel], s_bresp[sel]});
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    s_bvalid = 5'd0;
    hold     = 1'b0;
    sel      = 3'd0;
    m_bready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    hold     = 1'b0;
    sel      = 3'd0;
    m_bready = 1'b1;
    s_bvalid = 5'h1F;
    for (int i = 0; i < 5; i++) begin
      s_bid[i]   = SW'(i + 1);
      s_bresp[i] = 2'b00;
    end
    exp_q.delete();
    err_model = 0;
    @(negedge clk);
    #1;
    checks++; if (s_bready !== 5'd0) begin failures++; $display("FAIL reset_bready got=%b exp=%b", s_bready, 5'd0); end
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", m_bvalid); end
    checks++; if (m_bid !== 6'd0 || m_bresp !== 2'd0) begin failures++; $display("FAIL reset_mdata got=%h/%h exp=0/0", m_bid, m_bresp); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
    tick();
    tick();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL reset_hold_mvalid got=%b exp=0", m_bvalid); end
    s_bvalid = 5'd0;
    reset_n  = 1'b1;
    #1;
  endtask

  // First cycle after reset: s2 beat accepted, visible one cycle later.
  task automatic test_basic();
    sel        = 3'd2;
    s_bid[2]   = 6'h05;
    s_bresp[2] = 2'b00;
    s_bvalid   = 5'b00100;
    m_bready   = 1'b1;
    #1;
    checks++; if (s_bready !== 5'b00100) begin failures++; $display("FAIL basic_bready got=%b exp=%b", s_bready, 5'b00100); end
    tick();
    s_bvalid = 5'd0;
    #1;
    checks++; if (m_bvalid !== 1'b1 || m_bid !== 6'h05) begin failures++; $display("FAIL basic_out got=%b/%h exp=1/05", m_bvalid, m_bid); end
    tick();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", m_bvalid); end
  endtask

  // Three beats from s1 against a stalled master: third waits until space.
  task automatic test_full();
    m_bready   = 1'b0;
    sel        = 3'd1;
    s_bresp[1] = 2'b00;
    s_bvalid   = 5'b00010;
    s_bid[1]   = 6'd1;
    #1;
    checks++; if (s_bready !== 5'b00010) begin failures++; $display("FAIL full_acc1 got=%b exp=%b", s_bready, 5'b00010); end
    tick();
    s_bid[1] = 6'd2;
    #1;
    checks++; if (s_bready !== 5'b00010) begin failures++; $display("FAIL full_acc2 got=%b exp=%b", s_bready, 5'b00010); end
    tick();
    s_bid[1] = 6'd3;
    #1;
    checks++; if (s_bready !== 5'd0) begin failures++; $display("FAIL full_block3 got=%b exp=%b", s_bready, 5'd0); end
    tick();
    tick();
    checks++; if (m_bvalid !== 1'b1 || m_bid !== 6'd1) begin failures++; $display("FAIL full_stall_head got=%b/%h exp=1/01", m_bvalid, m_bid); end
    m_bready = 1'b1;
    #1;
    checks++; if (s_bready !== 5'd0) begin failures++; $display("FAIL full_pop_no_acc got=%b exp=%b", s_bready, 5'd0); end
    tick();
    checks++; if (m_bid !== 6'd2) begin failures++; $display("FAIL full_order2 got=%h exp=02", m_bid); end
    checks++; if (s_bready !== 5'b00010) begin failures++; $display("FAIL full_acc3 got=%b exp=%b", s_bready, 5'b00010); end
    tick();
    s_bvalid = 5'd0;
    checks++; if (m_bvalid !== 1'b1 || m_bid !== 6'd3) begin failures++; $display("FAIL full_order3 got=%b/%h exp=1/03", m_bvalid, m_bid); end
    tick();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", m_bvalid); end
  endtask

  task automatic test_hold();
    sel        = 3'd0;
    hold       = 1'b1;
    s_bid[0]   = 6'h11;
    s_bresp[0] = 2'b01;
    s_bvalid   = 5'b00001;
    m_bready   = 1'b1;
    #1;
    checks++; if (s_bready !== 5'd0) begin failures++; $display("FAIL hold_bready got=%b exp=%b", s_bready, 5'd0); end
    tick();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL hold_mvalid got=%b exp=0", m_bvalid); end
    hold = 1'b0;
    #1;
    checks++; if (s_bready !== 5'b00001) begin failures++; $display("FAIL hold_release got=%b exp=%b", s_bready, 5'b00001); end
    tick();
    s_bvalid = 5'd0;
    checks++; if (m_bvalid !== 1'b1 || m_bid !== 6'h11 || m_bresp !== 2'b01) begin failures++; $display("FAIL hold_out got=%b/%h/%b exp=1/11/01", m_bvalid, m_bid, m_bresp); end
    tick();
  endtask

  task automatic test_bad_sel();
    m_bready = 1'b1;
    s_bvalid = 5'h1F;
    for (int k = 5; k < 8; k++) begin
      sel = 3'(k);
      #1;
      checks++; if (s_bready !== 5'd0) begin failures++; $display("FAIL badsel_bready sel=%0d got=%b exp=%b", k, s_bready, 5'd0); end
      tick();
      checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL badsel_mvalid sel=%0d got=%b exp=0", k, m_bvalid); end
    end
    s_bvalid = 5'd0;
  endtask

  // One entry buffered, then accept and pop together.
  task automatic test_push_pop();
    m_bready   = 1'b0;
    sel        = 3'd3;
    s_bid[3]   = 6'h20;
    s_bresp[3] = 2'b00;
    s_bvalid   = 5'b01000;
    tick();
    s_bid[3] = 6'h0A;
    m_bready = 1'b1;
    #1;
    checks++; if (s_bready !== 5'b01000) begin failures++; $display("FAIL pushpop_bready got=%b exp=%b", s_bready, 5'b01000); end
    tick();
    s_bvalid = 5'd0;
    m_bready = 1'b0;
    #1;
    checks++; if (m_bvalid !== 1'b1 || m_bid !== 6'h0A) begin failures++; $display("FAIL pushpop_head got=%b/%h exp=1/0a", m_bvalid, m_bid); end
    tick();
    checks++; if (m_bid !== 6'h0A) begin failures++; $display("FAIL pushpop_stable got=%h exp=0a", m_bid); end
    m_bready = 1'b1;
    tick();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL pushpop_count1 got=%b exp=0", m_bvalid); end
  endtask

  // Random traffic checked cycle by cycle against the queue model.
  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      sel      = 3'($urandom_range(0, 7));
      s_bvalid = 5'($urandom);
      hold     = ($urandom_range(0, 3) == 0);
      m_bready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) begin
        s_bid[i]   = SW'($urandom);
        s_bresp[i] = 2'($urandom);
      end
      #1;
      checks++; if (s_bready !== exp_ready()) begin failures++; $display("FAIL b2b_bready cyc=%0d got=%b exp=%b", c, s_bready, exp_ready()); end
      checks++; if (m_bvalid !== (exp_q.size() != 0)) begin failures++; $display("FAIL b2b_mvalid cyc=%0d got=%b exp=%b", c, m_bvalid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({m_bid, m_bresp} !== exp_q[0]) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", c, {m_bid, m_bresp}, exp_q[0]); end
      end
      checks++; if (err_cnt !== (ERR_EN ? 8'(err_model) : 8'd0)) begin failures++; $display("FAIL b2b_errcnt cyc=%0d got=%0d exp=%0d", c, err_cnt, ERR_EN ? err_model : 0); end
      tick();
    end
    quiet();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", m_bvalid); end
  endtask

  task automatic test_err_cnt();
    reset_n = 1'b0;
    exp_q.delete();
    err_model = 0;
    @(negedge clk);
    #1;
    reset_n    = 1'b1;
    sel        = 3'd4;
    s_bresp[4] = 2'b10;
    s_bvalid   = 5'b10000;
    m_bready   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s_bid[4] = SW'(i);
      #1;
      if (i == 100) begin
        checks++; if (err_cnt !== (ERR_EN ? 8'd99 : 8'd0)) begin failures++; $display("FAIL err_mid got=%0d exp=%0d", err_cnt, ERR_EN ? 99 : 0); end
      end
      tick();
    end
    s_bvalid = 5'd0;
    tick();
    checks++; if (err_cnt !== (ERR_EN ? 8'd255 : 8'd0)) begin failures++; $display("FAIL err_sat got=%0d exp=%0d", err_cnt, ERR_EN ? 255 : 0); end
    // Reset asserted mid-burst, away from any clock edge.
    s_bresp[4] = 2'b11;
    s_bvalid   = 5'b10000;
    m_bready   = 1'b0;
    repeat (3) tick();
    checks++; if (m_bvalid !== 1'b1) begin failures++; $display("FAIL err_burst_valid got=%b exp=1", m_bvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (m_bvalid !== 1'b0 || err_cnt !== 8'd0) begin failures++; $display("FAIL err_async_rst got=%b/%0d exp=0/0", m_bvalid, err_cnt); end
    checks++; if (s_bready !== 5'd0) begin failures++; $display("FAIL err_rst_bready got=%b exp=%b", s_bready, 5'd0); end
    exp_q.delete();
    err_model = 0;
    @(negedge clk);
    #1;
    s_bvalid = 5'd0;
    reset_n  = 1'b1;
    m_bready = 1'b1;
    tick();
    checks++; if (m_bvalid !== 1'b0) begin failures++; $display("FAIL err_post_rst got=%b exp=0", m_bvalid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_full();
    test_hold();
    test_bad_sel();
    test_push_pop();
    test_back_to_back();
    test_err_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
